// File: rtl/cla16_rr_arbiter.sv
// cla16_rr_arbiter: round-robin share of one 16-bit CLA adder; define CLA16_ARB_SAT_EN for unsigned saturation.
// Latency: request handshake in cycle N -> rsp_valid in cycle N+2; one op in flight, at most one op per 3 cycles.
// Backpressure: result held stable until rsp_ready; req_ready stays low while a transaction is in flight.
module cla16_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_sum,
  output logic                 rsp_cout
);

  generate
    if (WIDTH != 16 || NREQ < 2 || NREQ > 8) begin : g_cfg_err
      $error("cla16_rr_arbiter: WIDTH must be 16 and NREQ must be 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  // 4-bit groups with generate/propagate lookahead between groups.
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p, g;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;
    logic [16:0] c;
    p = a ^ b;
    g = a & b;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = 1'b0;
    for (int k = 0; k < 4; k++) gc[k+1] = gg[k] | (gp[k] & gc[k]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
    end
    c[16] = gc[4];
    return {c[16], p ^ c[15:0]};
  endfunction

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [15:0]     op_a, op_b;
  logic [IDW-1:0]  op_id;
  logic [IDW-1:0]  grant;
  logic            any_req;
  logic [16:0]     sum_raw;
  logic [15:0]     sum_fin;

  // Scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        grant   = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && any_req) req_ready[grant] = 1'b1;
  end

  assign sum_raw = cla16(op_a, op_b);

`ifdef CLA16_ARB_SAT_EN
  assign sum_fin = sum_raw[16] ? 16'hFFFF : sum_raw[15:0];
`else
  assign sum_fin = sum_raw[15:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a   <= req_a[16*int'(grant) +: 16];
            op_b   <= req_b[16*int'(grant) +: 16];
            op_id  <= grant;
            rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= sum_fin;
          rsp_cout  <= sum_raw[16];
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla16_rr_arbiter.sv
// Bench for cla16_rr_arbiter: directed corner cases plus randomized traffic against a transaction-level model.
module tb_cla16_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*16-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_sum;
  logic                rsp_cout;

  always #5 clk = ~clk;

  cla16_rr_arbiter #(.NREQ(NREQ), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_on = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: first valid requester at or after ptr, wrapping.
  function automatic int first_from(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [16:0] model_res(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b};
`ifdef CLA16_ARB_SAT_EN
    if (r[16]) r = 17'h1FFFF;
`endif
    return r;
  endfunction

  // Transaction-level model: idle/busy, cycles since accept, pending result.
  int          m_ptr  = 0;
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_id   = 0;
  logic [16:0] m_res  = '0;
  int          g;
  logic [NREQ-1:0] exp_rdy;
  bit          exp_v;
  int          grants_id[$];
  int          grants_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_on) begin
        g = first_from(req_valid, m_ptr);
        exp_rdy = '0;
        if (!rst && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_v = m_busy && m_age >= 2;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v && rsp_valid) begin
          chk("rsp_id",   32'(rsp_id),   32'(m_id));
          chk("rsp_sum",  32'(rsp_sum),  32'(m_res[15:0]));
          chk("rsp_cout", 32'(rsp_cout), 32'(m_res[16]));
        end
        for (int k = 0; k < NREQ; k++)
          if (!rst && req_ready[k] && req_valid[k]) begin
            grants_id.push_back(k);
            grants_cyc.push_back(cyc);
          end
        if (rst) begin
          m_busy = 1'b0; m_ptr = 0; m_age = 0;
        end else if (m_busy) begin
          if (m_age >= 2) begin
            if (rsp_ready) m_busy = 1'b0;
          end else m_age++;
        end else if (g >= 0) begin
          m_busy = 1'b1;
          m_age  = 1;
          m_id   = g;
          m_res  = model_res(req_a[16*g +: 16], req_b[16*g +: 16]);
          m_ptr  = (g + 1) % NREQ;
        end
      end
    end
  end

  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [IDW-1:0] gid,
                       output logic [15:0] s, output logic c);
    bit ok;
    @(posedge clk); #1;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1'b1; break; end
    end
    chk("op_grant_seen", 32'(ok), 32'(1));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    ok = 1'b0; lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; lat = k; break; end
    end
    chk("op_rsp_seen", 32'(ok), 32'(1));
    gid = rsp_id; s = rsp_sum; c = rsp_cout;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'h0001;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  int              lat;
  logic [IDW-1:0]  gid;
  logic [15:0]     s;
  logic            c;
  logic [NREQ-1:0] hs;
  bit              ok;
  int              bad;

  initial begin
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    // Reset held two cycles with every requester valid.
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("reset_ready2", 32'(req_ready), 32'(0));
    chk("reset_valid", 32'(rsp_valid), 32'(0));
    chk("reset_id",    32'(rsp_id),    32'(0));
    chk("reset_sum",   32'(rsp_sum),   32'(0));
    chk("reset_cout",  32'(rsp_cout),  32'(0));
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;

    do_op(2, 16'h1234, 16'h4321, lat, gid, s, c);
    chk("single_lat", 32'(lat), 32'(2));
    chk("single_id",  32'(gid), 32'(2));
    chk("single_sum", 32'(s),   32'h5555);
    chk("single_cout", 32'(c),  32'(0));

    do_op(0, 16'hFFFF, 16'h0001, lat, gid, s, c);
`ifdef CLA16_ARB_SAT_EN
    chk("ovf_sum", 32'(s), 32'hFFFF);
`else
    chk("ovf_sum", 32'(s), 32'h0000);
`endif
    chk("ovf_cout", 32'(c), 32'(1));
    do_op(1, 16'hAAAA, 16'h5555, lat, gid, s, c);
    chk("prop_sum", 32'(s), 32'hFFFF);
    chk("prop_cout", 32'(c), 32'(0));
    do_op(3, 16'h7FFF, 16'h0001, lat, gid, s, c);
    chk("chain_sum", 32'(s), 32'h8000);

    // Round-robin with all requesters valid from a fresh pointer.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    grants_id.delete(); grants_cyc.delete();
    for (int k = 0; k < NREQ; k++) begin
      req_a[16*k +: 16] = 16'(100 * (k + 1));
      req_b[16*k +: 16] = 16'(k);
    end
    req_valid = '1; rsp_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1 req_valid = '0;
    chk("rr_count", 32'(grants_id.size() >= 5), 32'(1));
    if (grants_id.size() >= 5) begin
      chk("rr_g0", 32'(grants_id[0]), 32'(0));
      chk("rr_g1", 32'(grants_id[1]), 32'(1));
      chk("rr_g2", 32'(grants_id[2]), 32'(2));
      chk("rr_g3", 32'(grants_id[3]), 32'(3));
      chk("rr_g4", 32'(grants_id[4]), 32'(0));
      for (int k = 1; k < 5; k++)
        chk("rr_spacing", 32'(grants_cyc[k] - grants_cyc[k-1]), 32'(3));
    end
    repeat (4) @(posedge clk);

    // Backpressure on requester 3 while 0 and 1 wait.
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b0;
    req_a[48 +: 16] = 16'h00FF; req_b[48 +: 16] = 16'h0F01;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1 req_valid = 4'b0011;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("bp_rsp_seen", 32'(ok), 32'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_sum",   32'(rsp_sum),   32'h1000);
      chk("bp_id",    32'(rsp_id),    32'(3));
      chk("bp_ready", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_last", 32'(rsp_valid), 32'(1));
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'(0));
    chk("bp_wrap_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Reset during CALC of requester 1.
    #1;
    req_a[16 +: 16] = 16'h1111; req_b[16 +: 16] = 16'h2222;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rm_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 4'b0101;
    @(negedge clk);
    chk("rm_valid_in_rst", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rm_ptr_grant", 32'(req_ready), 32'(4'b0001));
    chk("rm_no_rsp", 32'(rsp_valid), 32'(0));
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_id == 2'd1) bad++;
    end
    chk("rm_id1_dropped", 32'(bad), 32'(0));
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      hs = req_ready & req_valid;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NREQ; k++) begin
        if (hs[k] || !req_valid[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_a[16*k +: 16] = rnd16();
            req_b[16*k +: 16] = rnd16();
            req_valid[k] = 1'b1;
          end else req_valid[k] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
